// File: rtl/music_note_seq.sv
// Note sequencer: walks the selected song's note ROM and times each note in beats.
// Optional MUSIC_LOOP_EN: restart the song at its end instead of holding silent with song_done.
module music_note_seq #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned NOTE_AW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         music_reg,
  input  logic               cnt_clc1,
  input  logic               play_en,
  input  logic [7:0]         rom_data,
  output logic [NOTE_AW+1:0] rom_addr,
  output logic [4:0]         tone_out,
  output logic               tone_vld,
  output logic               note_start,
  output logic               song_done
);

  localparam int unsigned PW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t             state, state_nxt;
  logic [NOTE_AW-1:0] note_idx, note_idx_nxt;
  logic [2:0]         beat_cnt, beat_cnt_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic [4:0]         tone_nxt;
  logic               note_start_nxt;
  logic               song_done_nxt;
  logic               presc_last;
  logic               to_end;

  assign rom_addr   = {music_reg, note_idx};
  assign tone_vld   = (state == S_PLAY) && play_en;
  assign presc_last = (presc == PW'(BEAT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      note_idx   <= '0;
      beat_cnt   <= '0;
      presc      <= '0;
      tone_out   <= '0;
      note_start <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      note_idx   <= note_idx_nxt;
      beat_cnt   <= beat_cnt_nxt;
      presc      <= presc_nxt;
      tone_out   <= tone_nxt;
      note_start <= note_start_nxt;
      song_done  <= song_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    note_idx_nxt   = note_idx;
    beat_cnt_nxt   = beat_cnt;
    presc_nxt      = presc;
    tone_nxt       = tone_out;
    note_start_nxt = 1'b0;
    song_done_nxt  = song_done;
    to_end         = 1'b0;

    if (cnt_clc1) begin
      note_idx_nxt  = '0;
      beat_cnt_nxt  = '0;
      presc_nxt     = '0;
      tone_nxt      = '0;
      song_done_nxt = 1'b0;
      state_nxt     = play_en ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (play_en) state_nxt = S_FETCH;
        end
        S_FETCH: begin
          state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (rom_data == 8'h00) begin
            to_end = 1'b1;
          end else begin
            tone_nxt       = rom_data[4:0];
            beat_cnt_nxt   = rom_data[7:5];
            presc_nxt      = '0;
            note_start_nxt = 1'b1;
            state_nxt      = S_PLAY;
          end
        end
        S_PLAY: begin
          // Everything freezes while paused; counting resumes from the same point.
          if (play_en) begin
            if (presc_last) begin
              presc_nxt = '0;
              if (beat_cnt == '0) begin
                note_idx_nxt = note_idx + NOTE_AW'(1);
                if (note_idx == '1) to_end = 1'b1;
                else                state_nxt = S_FETCH;
              end else begin
                beat_cnt_nxt = beat_cnt - 3'd1;
              end
            end else begin
              presc_nxt = presc + PW'(1);
            end
          end
        end
        S_END: begin
`ifdef MUSIC_LOOP_EN
          note_idx_nxt  = '0;
          song_done_nxt = 1'b0;
          state_nxt     = S_FETCH;
`else
          state_nxt     = S_END;
`endif
        end
        default: state_nxt = S_IDLE;
      endcase

      // End marker and index wrap share one exit: silence and flag completion.
      if (to_end) begin
        state_nxt     = S_END;
        tone_nxt      = '0;
        song_done_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_music_note_seq.sv
// Directed bench for music_note_seq (BEAT_CYCLES=4, NOTE_AW=3) with a registered ROM model.
module tb_music_note_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] music_reg;
  logic       cnt_clc1;
  logic       play_en;
  logic [7:0] rom_data;
  logic [4:0] rom_addr;
  logic [4:0] tone_out;
  logic       tone_vld;
  logic       note_start;
  logic       song_done;

  logic [7:0] rom [0:31];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  music_note_seq #(.BEAT_CYCLES(4), .NOTE_AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .music_reg  (music_reg),
    .cnt_clc1   (cnt_clc1),
    .play_en    (play_en),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .tone_out   (tone_out),
    .tone_vld   (tone_vld),
    .note_start (note_start),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'h2A;
    rom[8]  = 8'h25;
    rom[9]  = 8'h03;
    rom[10] = 8'h00;
    for (int i = 0; i < 8; i++) rom[16+i] = 8'(i + 1);

    rst = 1'b1; music_reg = 2'd1; cnt_clc1 = 1'b0; play_en = 1'b0;
    tick(2);
    check("rst_tone",  32'(tone_out),   32'd0);
    check("rst_vld",   32'(tone_vld),   32'd0);
    check("rst_start", 32'(note_start), 32'd0);
    check("rst_done",  32'(song_done),  32'd0);
    check("rst_addr",  32'(rom_addr),   32'd8);

    // Song 1: tone 5 for two beats, tone 3 for one beat, then end marker
    rst = 1'b0; play_en = 1'b1;
    tick(1);
    check("fetch0_addr", 32'(rom_addr), 32'd8);
    check("fetch0_vld",  32'(tone_vld), 32'd0);
    tick(2);
    check("n0_start", 32'(note_start), 32'd1);
    check("n0_tone",  32'(tone_out),   32'd5);
    check("n0_vld",   32'(tone_vld),   32'd1);
    tick(1);
    check("n0_start_pulse", 32'(note_start), 32'd0);
    tick(6);
    check("n0_last_vld",  32'(tone_vld), 32'd1);
    check("n0_last_tone", 32'(tone_out), 32'd5);
    tick(1);
    check("fetch1_vld",  32'(tone_vld), 32'd0);
    check("fetch1_addr", 32'(rom_addr), 32'd9);
    tick(2);
    check("n1_start", 32'(note_start), 32'd1);
    check("n1_tone",  32'(tone_out),   32'd3);

    // Clear mid-note restarts from note 0
    tick(1);
    cnt_clc1 = 1'b1;
    tick(1);
    cnt_clc1 = 1'b0;
    check("clr_vld",  32'(tone_vld), 32'd0);
    check("clr_addr", 32'(rom_addr), 32'd8);
    check("clr_tone", 32'(tone_out), 32'd0);
    tick(2);
    check("clr_restart_start", 32'(note_start), 32'd1);
    check("clr_restart_tone",  32'(tone_out),   32'd5);

    // Pause for 3 cycles mid-note
    tick(2);
    play_en = 1'b0;
    tick(1);
    check("pause_vld",  32'(tone_vld), 32'd0);
    check("pause_tone", 32'(tone_out), 32'd5);
    tick(2);
    play_en = 1'b1;
    tick(5);
    check("pause_late_vld",  32'(tone_vld), 32'd1);
    check("pause_late_addr", 32'(rom_addr), 32'd8);
    tick(1);
    check("pause_end_vld",  32'(tone_vld), 32'd0);
    check("pause_end_addr", 32'(rom_addr), 32'd9);
    tick(2);
    check("n1b_start", 32'(note_start), 32'd1);
    check("n1b_tone",  32'(tone_out),   32'd3);

    // End marker
    tick(6);
    check("end_done", 32'(song_done), 32'd1);
    check("end_tone", 32'(tone_out),  32'd0);
    check("end_vld",  32'(tone_vld),  32'd0);
`ifdef MUSIC_LOOP_EN
    tick(1);
    check("loop_done_pulse", 32'(song_done), 32'd0);
    check("loop_addr",       32'(rom_addr),  32'd8);
    tick(2);
    check("loop_start", 32'(note_start), 32'd1);
    check("loop_tone",  32'(tone_out),   32'd5);
`else
    tick(4);
    check("end_hold_done", 32'(song_done), 32'd1);
    check("end_hold_vld",  32'(tone_vld),  32'd0);
`endif
    cnt_clc1 = 1'b1;
    tick(1);
    cnt_clc1 = 1'b0;
    check("end_clr_done", 32'(song_done), 32'd0);
    check("end_clr_addr", 32'(rom_addr),  32'd8);

    // Asynchronous reset mid-PLAY
    tick(4);
    check("pre_rst_vld", 32'(tone_vld), 32'd1);
    rst = 1'b1; music_reg = 2'd0;
    #1;
    check("arst_tone",  32'(tone_out),   32'd0);
    check("arst_vld",   32'(tone_vld),   32'd0);
    check("arst_start", 32'(note_start), 32'd0);
    check("arst_addr",  32'(rom_addr),   32'd0);
    rst = 1'b0;
    tick(1);
    check("arst_fetch_addr", 32'(rom_addr), 32'd0);
    tick(2);
    check("song0_start", 32'(note_start), 32'd1);
    check("song0_tone",  32'(tone_out),   32'd10);

    // Song 2: eight one-beat notes, no marker, index wraps
    music_reg = 2'd2;
    cnt_clc1 = 1'b1;
    tick(1);
    cnt_clc1 = 1'b0;
    check("s2_addr", 32'(rom_addr), 32'd16);
    tick(14);
    check("s2_n2_start", 32'(note_start), 32'd1);
    check("s2_n2_tone",  32'(tone_out),   32'd3);
    tick(30);
    check("s2_n7_start", 32'(note_start), 32'd1);
    check("s2_n7_tone",  32'(tone_out),   32'd8);
    check("s2_n7_addr",  32'(rom_addr),   32'd23);
    tick(4);
    check("wrap_done", 32'(song_done), 32'd1);
    check("wrap_addr", 32'(rom_addr),  32'd16);
    check("wrap_vld",  32'(tone_vld),  32'd0);
`ifdef MUSIC_LOOP_EN
    tick(3);
    check("wrap_loop_start", 32'(note_start), 32'd1);
    check("wrap_loop_tone",  32'(tone_out),   32'd1);
`else
    tick(3);
    check("wrap_hold_done", 32'(song_done), 32'd1);
    music_reg = 2'd3;
    #1;
    check("msb_follow_addr", 32'(rom_addr), 32'd24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
